// File: rtl/mag_search_pkg.sv
// ---------------------------------------------------------------------------
// mag_search_pkg
//   Shared types and helpers for the magnitude-comparator search initiator.
//   - state_t       : controller state (IDLE / SEARCH)
//   - DEF_WIDTH     : default operand width
//   - FULL_MAX      : largest operand value at the default width
//   - DEF_MAX_STEPS : default probe limit (one more than the width)
//   - mid_of()      : midpoint of an inclusive [lo, hi] search interval
// ---------------------------------------------------------------------------
package mag_search_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        SEARCH = 1'b1
    } state_t;

    localparam int DEF_WIDTH     = 4;
    localparam int FULL_MAX      = (1 << DEF_WIDTH) - 1;
    localparam int DEF_MAX_STEPS = DEF_WIDTH + 1;

    // Bounds are carried as plain non-negative ints, so the sum never
    // overflows for any practical operand width.
    function automatic int mid_of(input int lo, input int hi);
        return (lo + hi) / 2;
    endfunction

endpackage

// File: rtl/mag_search_ctrl.sv
// ---------------------------------------------------------------------------
// mag_search_ctrl
//   Binary-search initiator for an external combinational magnitude
//   comparator. Drives probe onto the comparator X input and narrows the
//   interval [lo, hi] from the G/E/L answer until the hidden Y operand is
//   found, the comparator answers inconsistently, or the probe limit is hit.
//
// Ports
//   clk     : rising-edge clock
//   rst_n   : synchronous active-low reset
//   start   : request a search (accepted only in IDLE)
//   probe   : registered value driven to comparator X
//   cmp_g/e/l : comparator result for the current probe (X>Y / X=Y / X<Y)
//   busy    : high while searching
//   done    : one-cycle pulse when the search ends
//   found   : result valid (held until next start)
//   error   : inconsistency or timeout (held until next start)
//   result  : recovered Y (held until next start)
//   steps   : number of probes issued in the last/current search
// ---------------------------------------------------------------------------
module mag_search_ctrl
    import mag_search_pkg::*;
#(
    parameter int  WIDTH     = DEF_WIDTH,
    parameter int  MAX_STEPS = WIDTH + 1,
    localparam int STEPS_W   = $clog2(MAX_STEPS + 1)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    output logic [WIDTH-1:0]   probe,
    input  logic               cmp_g,
    input  logic               cmp_e,
    input  logic               cmp_l,
    output logic               busy,
    output logic               done,
    output logic               found,
    output logic               error,
    output logic [WIDTH-1:0]   result,
    output logic [STEPS_W-1:0] steps
);

    localparam int FULL = (1 << WIDTH) - 1;

    state_t               state_q,  state_d;
    logic [WIDTH:0]       lo_q,     lo_d;
    logic [WIDTH:0]       hi_q,     hi_d;
    logic [WIDTH-1:0]     probe_q,  probe_d;
    logic [WIDTH-1:0]     result_q, result_d;
    logic [STEPS_W-1:0]   steps_q,  steps_d;
    logic                 busy_q,   busy_d;
    logic                 done_q,   done_d;
    logic                 found_q,  found_d;
    logic                 error_q,  error_d;

    // Candidate bounds after this cycle's G/L answer. Signed ints so that
    // hi = mid-1 at mid=0 becomes -1 and is caught by the lo > hi test
    // instead of wrapping to a large positive bound.
    int mid_i;
    int new_lo_i;
    int new_hi_i;
    logic one_hot;

    always_comb begin
        mid_i    = mid_of(int'(lo_q), int'(hi_q));
        new_lo_i = cmp_l ? mid_i + 1 : int'(lo_q);
        new_hi_i = cmp_g ? mid_i - 1 : int'(hi_q);
        one_hot  = ({cmp_g, cmp_e, cmp_l} == 3'b100) ||
                   ({cmp_g, cmp_e, cmp_l} == 3'b010) ||
                   ({cmp_g, cmp_e, cmp_l} == 3'b001);
    end

    always_comb begin
        state_d  = state_q;
        lo_d     = lo_q;
        hi_d     = hi_q;
        probe_d  = probe_q;     // probe holds in IDLE so the comparator stays quiet
        result_d = result_q;
        steps_d  = steps_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        found_d  = found_q;
        error_d  = error_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = SEARCH;
                    lo_d    = '0;
                    hi_d    = (WIDTH + 1)'(FULL);
                    probe_d = WIDTH'(mid_of(0, FULL));
                    steps_d = STEPS_W'(1);
                    found_d = 1'b0;
                    error_d = 1'b0;
                    busy_d  = 1'b1;
                end
            end

            SEARCH: begin
                if ({cmp_g, cmp_e, cmp_l} == 3'b010) begin
                    result_d = probe_q;
                    found_d  = 1'b1;
                    done_d   = 1'b1;
                    busy_d   = 1'b0;
                    state_d  = IDLE;
                end else if (!one_hot || (steps_q == STEPS_W'(MAX_STEPS)) ||
                             (new_lo_i > new_hi_i)) begin
                    // Bad comparator code, probe budget exhausted, or the
                    // interval collapsed: abort without touching result.
                    error_d = 1'b1;
                    found_d = 1'b0;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end else begin
                    lo_d    = (WIDTH + 1)'(new_lo_i);
                    hi_d    = (WIDTH + 1)'(new_hi_i);
                    probe_d = WIDTH'(mid_of(new_lo_i, new_hi_i));
                    steps_d = steps_q + STEPS_W'(1);
                end
            end

            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            lo_q     <= '0;
            hi_q     <= (WIDTH + 1)'(FULL);
            probe_q  <= '0;
            result_q <= '0;
            steps_q  <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            found_q  <= 1'b0;
            error_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            lo_q     <= lo_d;
            hi_q     <= hi_d;
            probe_q  <= probe_d;
            result_q <= result_d;
            steps_q  <= steps_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            found_q  <= found_d;
            error_q  <= error_d;
        end
    end

    assign probe  = probe_q;
    assign result = result_q;
    assign steps  = steps_q;
    assign busy   = busy_q;
    assign done   = done_q;
    assign found  = found_q;
    assign error  = error_q;

endmodule

// File: tb/tb_mag_search_ctrl.sv
// ---------------------------------------------------------------------------
// tb_mag_search_ctrl
//   Bench for mag_search_ctrl with a behavioural comparator as responder.
//   Stimulus pushes expected probes and end-of-search records into queues;
//   a monitor on the falling edge pops and compares them.
// ---------------------------------------------------------------------------
module tb_mag_search_ctrl;
    import mag_search_pkg::*;

    localparam int W  = 4;
    localparam int MS = W + 1;
    localparam int SW = $clog2(MS + 1);

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic [W-1:0]  probe;
    logic          cmp_g, cmp_e, cmp_l;
    logic          busy, done, found, error;
    logic [W-1:0]  result;
    logic [SW-1:0] steps;

    int target = 0;
    bit force_bad = 1'b0;

    always #5 clk = ~clk;

    // Responder: ideal comparator X=probe, Y=target, with a fault override.
    always_comb begin
        cmp_g = !force_bad && (int'(probe) >  target);
        cmp_e = !force_bad && (int'(probe) == target);
        cmp_l = !force_bad && (int'(probe) <  target);
    end

    mag_search_ctrl #(.WIDTH(W), .MAX_STEPS(MS)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .probe(probe),
        .cmp_g(cmp_g), .cmp_e(cmp_e), .cmp_l(cmp_l),
        .busy(busy), .done(done), .found(found), .error(error),
        .result(result), .steps(steps)
    );

    typedef struct {
        bit found;
        bit error;
        int result;
        int steps;
    } exp_t;

    exp_t exp_q[$];
    int   probe_q[$];
    int   ref_list[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   model_result = 0;

    task automatic chk(input string name, input int act, input int expv);
        n_cmp++;
        if (act != expv) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, expv);
        end
    endtask

    // Reference: halve the candidate range [lo, hi] until the midpoint hits y.
    task automatic ref_search(input int y);
        int lo = 0;
        int hi = FULL_MAX;
        int m;
        ref_list.delete();
        forever begin
            m = (lo + hi) / 2;
            ref_list.push_back(m);
            if (m == y) break;
            if (m > y) hi = m - 1;
            else       lo = m + 1;
        end
    endtask

    // Monitor: every probe shown while busy, and every done record.
    always @(negedge clk) begin
        exp_t e;
        int   p;
        if (busy === 1'b1) begin
            if (probe_q.size() == 0) begin
                chk("unexpected_probe", int'(probe), -1);
            end else begin
                p = probe_q.pop_front();
                chk("probe", int'(probe), p);
            end
        end
        if (done === 1'b1) begin
            chk("busy_with_done", int'(busy), 0);
            if (exp_q.size() == 0) begin
                chk("unexpected_done", 1, 0);
            end else begin
                e = exp_q.pop_front();
                chk("found",  int'(found),  int'(e.found));
                chk("error",  int'(error),  int'(e.error));
                chk("result", int'(result), e.result);
                chk("steps",  int'(steps),  e.steps);
                $display("search done: found=%0d error=%0d result=%0d steps=%0d",
                         found, error, result, steps);
            end
        end
    end

    // One search. bad_at/pulse_at/reset_at are probe indices (0 = unused).
    task automatic run_search(input int y, input int bad_at, input int pulse_at,
                              input int reset_at);
        int n;
        int cyc;
        bit ended = 1'b0;
        ref_search(y);
        n = ref_list.size();
        if (bad_at > 0) n = bad_at;
        else if (reset_at > 0) n = reset_at;
        for (int i = 0; i < n; i++) probe_q.push_back(ref_list[i]);
        if (reset_at == 0) begin
            if (bad_at > 0) begin
                exp_q.push_back('{found: 1'b0, error: 1'b1, result: model_result, steps: n});
            end else begin
                exp_q.push_back('{found: 1'b1, error: 1'b0, result: y, steps: n});
                model_result = y;
            end
        end

        @(posedge clk); #1;
        target = y;
        start  = 1'b1;
        @(posedge clk); #1;
        start  = 1'b0;
        cyc    = 1;
        while (!ended && cyc <= 20) begin
            if (cyc == bad_at)   force_bad = 1'b1;
            if (cyc == pulse_at) start     = 1'b1;
            if (cyc == reset_at) rst_n     = 1'b0;
            @(posedge clk); #1;
            force_bad = 1'b0;
            start     = 1'b0;
            if (cyc == reset_at) begin
                rst_n = 1'b1;
                model_result = 0;
                chk("rst_busy",  int'(busy),  0);
                chk("rst_probe", int'(probe), 0);
                chk("rst_steps", int'(steps), 0);
                chk("rst_done",  int'(done),  0);
                ended = 1'b1;
            end else if (done) begin
                chk("latency", cyc, n);
                ended = 1'b1;
            end else begin
                cyc++;
            end
        end
        if (!ended) chk("done_timeout", 0, 1);
    endtask

    task automatic wait_done(output int cyc);
        cyc = 1;
        forever begin
            @(posedge clk); #1;
            if (done) return;
            cyc++;
            if (cyc > 20) begin
                chk("done_timeout", 0, 1);
                return;
            end
        end
    endtask

    initial begin
        int c;

        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        chk("reset_busy",   int'(busy),   0);
        chk("reset_done",   int'(done),   0);
        chk("reset_found",  int'(found),  0);
        chk("reset_error",  int'(error),  0);
        chk("reset_probe",  int'(probe),  0);
        chk("reset_result", int'(result), 0);
        chk("reset_steps",  int'(steps),  0);

        run_search(0,  0, 0, 0);
        run_search(15, 0, 0, 0);
        run_search(7,  0, 0, 0);
        run_search(10, 0, 0, 0);
        run_search(9,  2, 0, 0);   // forced 000 on the second probe
        run_search(5,  0, 0, 0);
        run_search(15, 0, 2, 0);   // start pulse mid-search is ignored

        // start held high: back-to-back searches, restart the cycle after done
        ref_search(15);
        for (int k = 0; k < 2; k++) begin
            foreach (ref_list[i]) probe_q.push_back(ref_list[i]);
            exp_q.push_back('{found: 1'b1, error: 1'b0, result: 15, steps: 5});
        end
        model_result = 15;
        @(posedge clk); #1;
        target = 15;
        start  = 1'b1;
        @(posedge clk); #1;
        wait_done(c);
        chk("held_latency1", c, 5);
        @(posedge clk); #1;
        chk("restart_busy",  int'(busy),  1);
        chk("restart_probe", int'(probe), 7);
        start = 1'b0;
        wait_done(c);
        chk("held_latency2", c, 5);

        run_search(12, 0, 0, 3);   // reset during the third probe
        run_search(12, 0, 0, 0);

        for (int i = 0; i < 20; i++) begin
            run_search(int'($urandom_range(0, FULL_MAX)), 0, 0, 0);
        end

        repeat (3) @(posedge clk);
        #1;
        chk("probes_left",  probe_q.size(), 0);
        chk("records_left", exp_q.size(),   0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
